// File: rtl/s1_serial_tx.sv
// Serial transmitter for the RB1->RB2 link: loads RB1, bit-transposes it into
// NPKT packets and shifts each out as {address, data} frames on sen/sd.
module s1_serial_tx #(
    parameter int NWORDS = 18,
    parameter int NPKT   = 8,
    parameter int ABITS  = 3,
    parameter int GAP    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      RB1_RW,
    output logic [$clog2(NWORDS)-1:0] RB1_A,
    output logic [NPKT-1:0]           RB1_D,
    input  logic [NPKT-1:0]           RB1_Q,
    output logic                      sen,
    output logic                      sd,
    output logic                      S1_done
);
    localparam int FBITS = ABITS + NWORDS;
    localparam int BW    = $clog2(FBITS);
    localparam int LW    = $clog2(NWORDS + 1);
    localparam int AW    = $clog2(NWORDS);
    localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [LW-1:0]    r_lcnt;
    logic [BW-1:0]    r_bit;
    logic [ABITS-1:0] r_pkt;
    logic [GW-1:0]    r_gcnt;
    logic [NPKT-1:0]  r_buf [NWORDS];

    logic [ABITS-1:0] w_nk;
    logic [BW-1:0]    w_ni;
    logic [FBITS-1:0] w_frame;
    logic             w_sd_nxt;

    assign RB1_RW = 1'b1;
    assign RB1_D  = '0;

    // Coordinates (packet, frame bit) of the bit that goes on sd next cycle.
    always_comb begin
        w_nk = r_pkt;
        w_ni = r_bit - 1'b1;
        if (r_state == S_LOAD) begin
            w_nk = '0;
            w_ni = BW'(FBITS - 1);
        end else if (r_state == S_GAP || r_bit == '0) begin
            w_nk = r_pkt + 1'b1;
            w_ni = BW'(FBITS - 1);
        end
    end

    assign w_frame[FBITS-1 -: ABITS] = w_nk;
    for (genvar b = 0; b < NWORDS; b++) begin : g_xpose
        assign w_frame[b] = r_buf[b][w_nk];
    end
    assign w_sd_nxt = w_frame[w_ni];

    // Buffer is deliberately not reset; every run reloads it before use.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && r_lcnt != '0)
            r_buf[r_lcnt - 1'b1] <= RB1_Q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
            r_lcnt  <= '0;
            r_bit   <= '0;
            r_pkt   <= '0;
            r_gcnt  <= '0;
            RB1_A   <= '0;
            sen     <= 1'b0;
            sd      <= 1'b0;
            S1_done <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (r_lcnt < LW'(NWORDS - 1))
                        RB1_A <= AW'(r_lcnt + 1'b1);
                    if (r_lcnt == LW'(NWORDS)) begin
                        r_state <= S_SEND;
                        r_pkt   <= '0;
                        r_bit   <= BW'(FBITS - 1);
                        sen     <= 1'b1;
                        sd      <= w_sd_nxt;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (r_bit == '0) begin
                        if (r_pkt == ABITS'(NPKT - 1)) begin
                            r_state <= S_DONE;
                            sen     <= 1'b0;
                            sd      <= 1'b0;
                            S1_done <= 1'b1;
                        end else if (GAP > 0) begin
                            r_state <= S_GAP;
                            r_gcnt  <= '0;
                            sen     <= 1'b0;
                            sd      <= 1'b0;
                        end else begin
                            r_pkt <= r_pkt + 1'b1;
                            r_bit <= BW'(FBITS - 1);
                            sd    <= w_sd_nxt;
                        end
                    end else begin
                        r_bit <= r_bit - 1'b1;
                        sd    <= w_sd_nxt;
                    end
                end
                S_GAP: begin
                    if (r_gcnt == GW'(GAP - 1)) begin
                        r_state <= S_SEND;
                        r_pkt   <= r_pkt + 1'b1;
                        r_bit   <= BW'(FBITS - 1);
                        sen     <= 1'b1;
                        sd      <= w_sd_nxt;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                S_DONE: ;
                default: r_state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_s1_serial_tx.sv
// Bench for s1_serial_tx: a GAP=0 and a GAP=2 instance share clock and reset;
// outputs are recorded per cycle and decoded against a transpose model.
module tb_s1_serial_tx;
    localparam int NC = 240;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rw   [2];
    logic [4:0] a    [2];
    logic [7:0] dd   [2];
    logic [7:0] qq   [2];
    logic       sen  [2];
    logic       sd   [2];
    logic       done [2];

    logic [7:0]  mem [2][32];
    logic [17:0] rb2 [2][8];

    bit s_sen [2][NC];
    bit s_sd  [2][NC];
    bit s_dn  [2][NC];
    bit s_rw  [2][NC];
    int s_a   [2][NC];
    int s_d   [2][NC];
    bit st    [2][NC];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    s1_serial_tx #(.GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .RB1_RW(rw[0]), .RB1_A(a[0]), .RB1_D(dd[0]),
        .RB1_Q(qq[0]), .sen(sen[0]), .sd(sd[0]), .S1_done(done[0])
    );
    s1_serial_tx #(.GAP(2)) u_dut2 (
        .clk(clk), .rst(rst), .RB1_RW(rw[1]), .RB1_A(a[1]), .RB1_D(dd[1]),
        .RB1_Q(qq[1]), .sen(sen[1]), .sd(sd[1]), .S1_done(done[1])
    );

    // RB1 model: read data appears the cycle after the address.
    always @(posedge clk) begin
        qq[0] <= mem[0][a[0]];
        qq[1] <= mem[1][a[1]];
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] xpose(int i, int k);
        logic [17:0] r;
        for (int b = 0; b < 18; b++) r[b] = mem[i][b][k];
        return r;
    endfunction

    task automatic fill(int i, int mode);
        for (int w = 0; w < 32; w++) begin
            case (mode)
                0: mem[i][w] = 8'(w);
                1: mem[i][w] = 8'hFF;
                2: mem[i][w] = (w == 5) ? 8'h08 : 8'h00;
                default: mem[i][w] = 8'($urandom);
            endcase
        end
    endtask

    task automatic run_capture(int ncyc);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                s_sen[i][c] = sen[i];
                s_sd[i][c]  = sd[i];
                s_dn[i][c]  = done[i];
                s_rw[i][c]  = rw[i];
                s_a[i][c]   = int'(a[i]);
                s_d[i][c]   = int'(dd[i]);
            end
        end
    endtask

    task automatic analyze(string nm, int i, int g);
        int rise = -1, dn = -1, runs = 0, rlbad = 0, gapbad = 0, ngaps = 0;
        int zlen = 0, sdbad = 0, abad = 0, cbad = 0, stick = 0, n = 0, cur = 0;
        int exp_run = (g == 0) ? 168 : 21;
        bit in_run = 0;
        for (int c = 0; c < NC; c++) begin
            if (s_sen[i][c]) begin
                if (rise < 0) rise = c;
                if (!in_run) begin
                    if (runs > 0) begin
                        ngaps++;
                        if (zlen != g) gapbad++;
                    end
                    runs++;
                    cur = 0;
                end
                in_run = 1;
                cur++;
                zlen = 0;
                st[i][n] = s_sd[i][c];
                n++;
            end else begin
                if (in_run && cur != exp_run) rlbad++;
                in_run = 0;
                zlen++;
                if (s_sd[i][c]) sdbad++;
            end
            if (s_dn[i][c] && dn < 0) dn = c;
            if (dn >= 0 && !s_dn[i][c]) stick++;
            if (s_a[i][c] != ((c < 17) ? c : 17)) abad++;
            if (!s_rw[i][c] || s_d[i][c] != 0) cbad++;
        end
        if (in_run && cur != exp_run) rlbad++;
        chk({nm, ".sen_rise"}, rise, 19);
        chk({nm, ".done_rise"}, dn, 19 + 168 + 7 * g);
        chk({nm, ".done_sticky"}, stick, 0);
        chk({nm, ".runs"}, runs, (g == 0) ? 1 : 8);
        chk({nm, ".runlen"}, rlbad, 0);
        chk({nm, ".ngaps"}, ngaps, (g == 0) ? 0 : 7);
        chk({nm, ".gaplen"}, gapbad, 0);
        chk({nm, ".sd_idle"}, sdbad, 0);
        chk({nm, ".addr_sweep"}, abad, 0);
        chk({nm, ".rw_d"}, cbad, 0);
        chk({nm, ".nbits"}, n, 168);
        for (int k = 0; k < 8; k++) rb2[i][k] = '0;
        if (n >= 168) begin
            for (int k = 0; k < 8; k++) begin
                logic [2:0]  pa;
                logic [17:0] pd;
                for (int j = 0; j < 3; j++) pa[2-j] = st[i][21*k + j];
                for (int j = 0; j < 18; j++) pd[17-j] = st[i][21*k + 3 + j];
                chk($sformatf("%s.paddr%0d", nm, k), pa, k);
                rb2[i][pa] = pd;
            end
        end
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s.rb2_%0d", nm, k), rb2[i][k], xpose(i, k));
    endtask

    initial begin
        int ones;
        fill(0, 0);
        fill(1, 3);
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d.sen", i), sen[i], 0);
            chk($sformatf("rst%0d.sd", i), sd[i], 0);
            chk($sformatf("rst%0d.done", i), done[i], 0);
            chk($sformatf("rst%0d.a", i), a[i], 0);
            chk($sformatf("rst%0d.rw", i), rw[i], 1);
            chk($sformatf("rst%0d.d", i), dd[i], 0);
        end

        // RB1[a]=a
        run_capture(NC);
        analyze("inc", 0, 0);
        analyze("rndA_gap2", 1, 2);
        chk("inc.frame0", rb2[0][0], 18'h2AAAA);

        // all ones
        fill(0, 1);
        fill(1, 3);
        run_capture(NC);
        analyze("ff", 0, 0);
        analyze("rndB_gap2", 1, 2);
        chk("ff.frame7", rb2[0][7], 18'h3FFFF);

        // single set bit: RB1[5] bit 3
        fill(0, 2);
        fill(1, 3);
        run_capture(NC);
        analyze("one", 0, 0);
        analyze("rndC_gap2", 1, 2);
        ones = 0;
        for (int j = 0; j < 168; j++) ones += int'(st[0][j]);
        chk("one.ones", ones, 12 + 1);
        chk("one.pos", st[0][3*21 + 15], 1);
        chk("one.frame3", rb2[0][3], 18'h00020);

        // reset in the middle of frame 4, bit 10
        fill(0, 3);
        fill(1, 3);
        run_capture(114);
        chk("mid.pre_sen0", s_sen[0][113], 1);
        chk("mid.pre_sen2", s_sen[1][113], 1);
        #2 rst = 1'b0;
        #1;
        chk("mid.sen0", sen[0], 0);
        chk("mid.sd0", sd[0], 0);
        chk("mid.done0", done[0], 0);
        chk("mid.a0", a[0], 0);
        chk("mid.sen2", sen[1], 0);
        chk("mid.sd2", sd[1], 0);
        repeat (2) @(negedge clk);
        run_capture(NC);
        analyze("rerun", 0, 0);
        analyze("rerun_gap2", 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
